// File: rtl/aes_sbox.sv
// Forward AES S-box: combinational 8-bit substitution (FIPS-197 table).
// Ports:
//    value  - input byte
//    result - substituted byte
module aes_sbox (
   input  logic [7:0] value,
   output logic [7:0] result
);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
      8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
      8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
      8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
      8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
      8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
      8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
      8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
      8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
      8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
      8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
      8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
      8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
      8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
      8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
      8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
      8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   assign result = SBOX[value];

endmodule

// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core, one round per clock with on-the-fly key expansion.
// Ports:
//    clk         - system clock, rising edge
//    rest        - asynchronous active-low reset
//    s           - start strobe; accepted in IDLE or DONE
//    plaintext   - 128-bit block, [127:120] = state byte 0, column-major
//    local_key   - 128-bit cipher key, same byte order
//    cipher_text - ciphertext result register
//    d           - one-cycle done pulse when cipher_text becomes valid
//    a           - busy, high for the 10 round cycles of an encryption
module aes_encrypt #(
   parameter bit CLEAR_ON_START = 1'b1
) (
   input  logic         clk,
   input  logic         rest,
   input  logic         s,
   input  logic [127:0] plaintext,
   input  logic [127:0] local_key,
   output logic [127:0] cipher_text,
   output logic         d,
   output logic         a
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} fsm_e;

   fsm_e         fsm_q, fsm_d;
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] ct_q, ct_d;
   logic [3:0]   round_q, round_d;
   logic         done_q, done_d;
   logic         busy_q, busy_d;

   logic [127:0] sub_bytes, shift_rows, mix_cols, next_rkey, round_out;
   logic [31:0]  rot_word, sub_word;
   logic [31:0]  w0, w1, w2, w3;
   logic [7:0]   rcon;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // 16 S-boxes for SubBytes, 4 for SubWord(RotWord(w3)).
   for (genvar i = 0; i < 16; i++) begin : g_state_sbox
      aes_sbox u_sbox (
         .value  (state_q[127-8*i -: 8]),
         .result (sub_bytes[127-8*i -: 8])
      );
   end

   assign rot_word = {rkey_q[23:0], rkey_q[31:24]};

   for (genvar j = 0; j < 4; j++) begin : g_key_sbox
      aes_sbox u_sbox (
         .value  (rot_word[31-8*j -: 8]),
         .result (sub_word[31-8*j -: 8])
      );
   end

   always_comb begin
      rcon = 8'h00;
      case (round_q)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   always_comb begin
      w0 = rkey_q[127:96] ^ sub_word ^ {rcon, 24'h000000};
      w1 = rkey_q[95:64] ^ w0;
      w2 = rkey_q[63:32] ^ w1;
      w3 = rkey_q[31:0] ^ w2;
      next_rkey = {w0, w1, w2, w3};
   end

   // Row r of column c takes the byte from column (c + r) mod 4.
   always_comb begin
      shift_rows = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_rows[127-8*(4*c+r) -: 8] = sub_bytes[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
   end

   always_comb begin
      mix_cols = '0;
      for (int c = 0; c < 4; c++) begin
         mix_cols[127-32*c -: 32] = mix_column(shift_rows[127-32*c -: 32]);
      end
   end

   assign round_out = ((round_q == 4'd10) ? shift_rows : mix_cols) ^ next_rkey;

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      rkey_d  = rkey_q;
      ct_d    = ct_q;
      round_d = round_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      unique case (fsm_q)
         StIdle, StDone: begin
            if (s) begin
               state_d = plaintext ^ local_key;
               rkey_d  = local_key;
               round_d = 4'd1;
               busy_d  = 1'b1;
               fsm_d   = StRun;
               if (CLEAR_ON_START) begin
                  ct_d = '0;
               end
            end else begin
               fsm_d = StIdle;
            end
         end
         StRun: begin
            rkey_d  = next_rkey;
            state_d = round_out;
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
               ct_d   = round_out;
               done_d = 1'b1;
               busy_d = 1'b0;
               fsm_d  = StDone;
            end
         end
         default: begin
            fsm_d  = StIdle;
            busy_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         fsm_q   <= StIdle;
         state_q <= '0;
         rkey_q  <= '0;
         ct_q    <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         rkey_q  <= rkey_d;
         ct_q    <= ct_d;
         round_q <= round_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign cipher_text = ct_q;
   assign d           = done_q;
   assign a           = busy_q;

endmodule

// File: tb/tb_aes_encrypt.sv
// Self-checking bench for aes_encrypt: directed vectors, scoreboard of expected ciphertexts,
// and an independent inverse-cipher model for the loopback check.
module tb_aes_encrypt;

   localparam logic [127:0] V1_PT  = 128'h54776F204F6E65204E696E652054776F;
   localparam logic [127:0] V1_KEY = 128'h5468617473206D79204B756E67204675;
   localparam logic [127:0] V1_CT  = 128'h29C3505F571420F6402299B31A02D73A;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk = 1'b0;
   logic         rest;
   logic         s;
   logic [127:0] plaintext;
   logic [127:0] local_key;
   logic [127:0] cipher_text;
   logic         d;
   logic         a;

   int checks   = 0;
   int failures = 0;
   logic [127:0] exp_q [$];
   logic [7:0]   sbox_m  [256];
   logic [7:0]   isbox_m [256];

   always #5 clk = ~clk;

   aes_encrypt #(
      .CLEAR_ON_START (1'b1)
   ) dut (
      .clk         (clk),
      .rest        (rest),
      .s           (s),
      .plaintext   (plaintext),
      .local_key   (local_key),
      .cipher_text (cipher_text),
      .d           (d),
      .a           (a)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = x;
      logic [7:0] bb = y;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // S-box derived from GF(2^8) inverse plus affine transform.
   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_m[x]  = b;
         isbox_m[b] = 8'(x);
      end
   endtask

   function automatic logic [31:0] inv_mix(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
              gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
              gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
              gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
   endfunction

   function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input logic [127:0] key);
      logic [127:0] rk [11];
      logic [127:0] st, tmp;
      logic [31:0]  w0, w1, w2, w3, t;
      logic [7:0]   rc;
      rk[0] = key;
      rc    = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         w3 = rk[r-1][31:0];
         t  = {sbox_m[w3[23:16]], sbox_m[w3[15:8]], sbox_m[w3[7:0]], sbox_m[w3[31:24]]}
              ^ {rc, 24'h000000};
         w0 = rk[r-1][127:96] ^ t;
         w1 = rk[r-1][95:64] ^ w0;
         w2 = rk[r-1][63:32] ^ w1;
         w3 = rk[r-1][31:0] ^ w2;
         rk[r] = {w0, w1, w2, w3};
         rc = gmul(rc, 8'h02);
      end
      st = ct ^ rk[10];
      for (int r = 9; r >= 0; r--) begin
         tmp = st;
         for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
               st[127-8*(4*((c+rr)%4)+rr) -: 8] = isbox_m[tmp[127-8*(4*c+rr) -: 8]];
            end
         end
         st = st ^ rk[r];
         if (r > 0) begin
            for (int c = 0; c < 4; c++) st[127-32*c -: 32] = inv_mix(st[127-32*c -: 32]);
         end
      end
      return st;
   endfunction

   task automatic start_block(input logic [127:0] pt, input logic [127:0] key,
                              input logic [127:0] expv, input bit hold);
      @(negedge clk);
      plaintext = pt;
      local_key = key;
      s         = 1'b1;
      exp_q.push_back(expv);
      @(posedge clk);
      if (!hold) begin
         #1 s = 1'b0;
      end
   endtask

   // Waits for d (bounded), pops the scoreboard and compares; latency counts posedges from accept.
   task automatic wait_done(input string tag, input int consumed, output int a_cnt);
      bit           seen = 1'b0;
      int           lat  = -1;
      logic [127:0] expv;
      a_cnt = 0;
      for (int i = consumed; i < consumed + 40 && !seen; i++) begin
         @(negedge clk);
         if (a) a_cnt++;
         if (d) begin
            seen = 1'b1;
            lat  = i;
         end
      end
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({tag, "_latency"}, 128'(lat), 128'd10);
      check({tag, "_cipher_text"}, cipher_text, expv);
      check({tag, "_a_low_at_done"}, 128'(a), 128'd0);
   endtask

   task automatic quiet_window(input string tag);
      int d_cnt = 0;
      int a_cnt = 0;
      repeat (15) begin
         @(negedge clk);
         if (d) d_cnt++;
         if (a) a_cnt++;
      end
      check({tag, "_extra_d"}, 128'(d_cnt), 128'd0);
      check({tag, "_extra_a"}, 128'(a_cnt), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int acnt;
      build_sbox();
      rest      = 1'b0;
      s         = 1'b0;
      plaintext = '0;
      local_key = '0;
      repeat (2) @(negedge clk);
      check("reset_cipher_text", cipher_text, 128'd0);
      check("reset_d", 128'(d), 128'd0);
      check("reset_a", 128'(a), 128'd0);
      rest = 1'b1;

      // Basic vector, busy window, pulse width, hold and loopback.
      start_block(V1_PT, V1_KEY, V1_CT, 1'b0);
      wait_done("v1", 0, acnt);
      check("v1_a_cycles", 128'(acnt), 128'd10);
      check("v1_loopback", inv_cipher(cipher_text, V1_KEY), V1_PT);
      @(negedge clk);
      check("v1_d_one_cycle", 128'(d), 128'd0);
      check("v1_a_idle", 128'(a), 128'd0);
      repeat (3) @(negedge clk);
      check("v1_hold", cipher_text, V1_CT);

      // FIPS-197 C.1; result register cleared at the accept edge.
      start_block(C1_PT, C1_KEY, C1_CT, 1'b0);
      @(negedge clk);
      check("c1_clear_on_start", cipher_text, 128'd0);
      wait_done("c1", 1, acnt);
      check("c1_a_cycles", 128'(acnt), 128'd9);

      // FIPS-197 B with input changes and a start pulse during RUN.
      start_block(B_PT, B_KEY, B_CT, 1'b0);
      repeat (3) @(negedge clk);
      plaintext = ~B_PT;
      local_key = ~B_KEY;
      s         = 1'b1;
      @(negedge clk);
      s = 1'b0;
      wait_done("b_run", 4, acnt);
      quiet_window("b_after");

      // Back-to-back with s held high: C.1 then B, d pulses 11 cycles apart.
      start_block(C1_PT, C1_KEY, C1_CT, 1'b1);
      @(negedge clk);
      plaintext = B_PT;
      local_key = B_KEY;
      exp_q.push_back(B_CT);
      wait_done("b2b_c1", 1, acnt);
      check("b2b_c1_a_cycles", 128'(acnt), 128'd9);
      @(posedge clk);
      #1 s = 1'b0;
      wait_done("b2b_b", 0, acnt);
      check("b2b_b_a_cycles", 128'(acnt), 128'd10);
      @(negedge clk);
      check("b2b_d_fall", 128'(d), 128'd0);

      // Reset at round 5 aborts; then a fresh start completes normally.
      start_block(V1_PT, V1_KEY, V1_CT, 1'b0);
      repeat (5) @(negedge clk);
      #2 rest = 1'b0;
      #1;
      check("abort_a", 128'(a), 128'd0);
      check("abort_d", 128'(d), 128'd0);
      check("abort_cipher_text", cipher_text, 128'd0);
      void'(exp_q.pop_back());
      @(negedge clk);
      rest = 1'b1;
      quiet_window("abort_after");
      start_block(V1_PT, V1_KEY, V1_CT, 1'b0);
      wait_done("v1_again", 0, acnt);
      check("v1_again_a_cycles", 128'(acnt), 128'd10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
